ahb_itcm_slv: RTL

- AHB-Lite responder for the instruction TCM; it is the slave end of the fetch bus that the ifu_swc master drives.
- Contains a word-organised RAM and returns fetch data with a configurable number of wait states.
- Accepts data writes for program load and signals ERROR on illegal transfers.
- Clears the RAM after reset and drives itcm_ready so the IFU holds off until the TCM is usable.

---
 rtl/ahb_itcm_slv.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ahb_itcm_slv.sv
// AHB-Lite instruction TCM responder: word RAM cleared by a post-reset sweep,
// configurable wait states on OKAY data phases and a two-cycle ERROR response.
module ahb_itcm_slv #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [6:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        itcm_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          pend_q, pend_d;
  logic [2:0]    wcnt_q, wcnt_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic [31:0]   off;
  logic          accept;
  logic          range_err, size_err, align_err, xfer_err;
  logic [3:0]    be;
  logic          unused_ok;

  assign off       = haddr - ADDR_BASE;
  assign accept    = hsel && htrans[1] && hready;
  // Unsigned offset handles addresses below the base by wrapping to a huge value.
  assign range_err = (off >> (AW + 2)) != 32'd0;
  assign size_err  = hsize > 3'd2;
  assign align_err = ((hsize == 3'd1) && haddr[0]) ||
                     ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign xfer_err  = range_err || size_err || align_err;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], off[1:0]};

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    write_d   = write_q;
    pend_d    = pend_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    mem_widx  = cnt_q;
    mem_wdata = 32'd0;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH_WORDS - 1)) state_d = S_IDLE;
      end
      S_IDLE, S_ERR2: begin
        if (state_q == S_IDLE && pend_q && write_q) begin
          mem_we   = 1'b1;
          mem_widx = idx_q;
          for (int i = 0; i < 4; i++) begin
            mem_wdata[8*i +: 8] = be[i] ? hwdata[8*i +: 8] : mem_q[idx_q][8*i +: 8];
          end
        end
        pend_d  = 1'b0;
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = off[AW+1:2];
          lane_d  = haddr[1:0];
          size_d  = hsize[1:0];
          write_d = hwrite;
          if (xfer_err) begin
            state_d = S_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              wcnt_d  = 3'(WAIT_STATES - 1);
            end
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 3'd0) state_d = S_IDLE;
        else                wcnt_d  = wcnt_q - 1'b1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      pend_q  <= 1'b0;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // RAM content is defined by the INIT sweep, so the array itself has no reset.
  always_ff @(posedge hclk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign hready     = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign hresp      = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign itcm_ready = state_q != S_INIT;
  // Writes commit on the edge before a following read's data phase, so the
  // asynchronous read sees merged data without a separate bypass path.
  assign hrdata     = (state_q == S_IDLE && pend_q && !write_q) ? mem_q[idx_q] : 32'd0;

endmodule
